data_mem_responder: RTL and testbench

//   Responder end of the CPU MEM-stage data port (en / byte-wen / addr / wdata -> rdata).

---
 rtl/data_mem_responder.sv | 124 ++++++++++++
 tb/tb_data_mem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data port responder backed by a wait-stated, word-organised synchronous RAM.
// Define DMEM_RANGE_CHECK_EN to flag and suppress accesses above the RAM's byte range.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [3:0]  wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [3:0]            r_wen;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_abort;
  logic                  w_access;
  logic                  w_accOob;
  logic [3:0]            w_accWen;
  logic [ADDR_WIDTH-1:0] w_accIdx;
  logic [ADDR_WIDTH-1:0] w_idxIn;
  logic [31:0]           w_accWdata;
  logic                  w_unusedBits;

  assign w_idxIn  = addr_i[ADDR_WIDTH+1:2];
  assign w_accept = (r_state == IDLE) && en_i && !flush_i;
  assign w_abort  = (r_state == BUSY) && flush_i && (r_wen == 4'h0);

  // With zero wait states the access happens on the accept edge, straight from the live inputs.
  assign w_access   = (WAIT_CYCLES == 0) ? w_accept
                                         : ((r_state == BUSY) && (r_cnt == 4'd0) && !w_abort);
  assign w_accWen   = (r_state == IDLE) ? wen_i   : r_wen;
  assign w_accIdx   = (r_state == IDLE) ? w_idxIn : r_idx;
  assign w_accWdata = (r_state == IDLE) ? wdata_i : r_wdata;

  assign stall_o = w_accept || (r_state == BUSY);
  assign rdata_o = r_rdata;

`ifdef DMEM_RANGE_CHECK_EN
  logic w_oob;
  logic r_oob;
  logic r_err;

  assign w_oob        = |addr_i[31:ADDR_WIDTH+2];
  assign w_accOob     = (r_state == IDLE) ? w_oob : r_oob;
  assign w_unusedBits = ^addr_i[1:0];
  assign err_o        = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_oob <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) r_oob <= w_oob;
      r_err <= w_access && w_accOob;
    end
  end
`else
  assign w_accOob     = 1'b0;
  assign w_unusedBits = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};
  assign err_o        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_wen   <= 4'h0;
      r_idx   <= '0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      if (w_access && (w_accWen == 4'h0)) r_rdata <= w_accOob ? 32'h0 : r_mem[w_accIdx];
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wen   <= wen_i;
            r_idx   <= w_idxIn;
            r_wdata <= wdata_i;
            r_cnt   <= CNT_LOAD;
            r_state <= (WAIT_CYCLES == 0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (w_abort)               r_state <= IDLE;
          else if (r_cnt == 4'd0)    r_state <= DONE;
          else                       r_cnt   <= r_cnt - 4'd1;
        end
        DONE: begin
          if (flush_i || !hold_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is never cleared; reset only blocks a write that would land on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst && w_access && !w_accOob) begin
      for (int k = 0; k < 4; k++) begin
        if (w_accWen[k]) r_mem[w_accIdx][8*k +: 8] <= w_accWdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (ADDR_WIDTH=10, WAIT_CYCLES=2).
// Covers latency, byte lanes, hold, flush, reset mid-write, and aliasing or DMEM_RANGE_CHECK_EN checks.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic [3:0]  wen_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        hold_i;
  logic        flush_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .wen_i   (wen_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .hold_i  (hold_i),
    .flush_i (flush_i),
    .rdata_o (rdata_o),
    .stall_o (stall_o),
    .err_o   (err_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a request and counts the cycles stall_o is high, leaving the bench in the first non-stalled cycle.
  task automatic applyStimulus(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                               output int stallCycles);
    en_i = 1'b1; wen_i = wen; addr_i = addr; wdata_i = wdata;
    stallCycles = 0;
    #1;
    while (stall_o && stallCycles < 20) begin
      stallCycles++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic writeWord(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] wen);
    int s;
    applyStimulus(wen, addr, data, s);
    checkOutput({tag, " stall cycles"}, 32'(s), 32'd3);
    en_i = 1'b0;
    tick();
  endtask

  task automatic readWord(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    int s;
    applyStimulus(4'h0, addr, 32'h0, s);
    checkOutput({tag, " stall cycles"}, 32'(s), 32'd3);
    checkOutput({tag, " rdata"}, rdata_o, expected);
    checkOutput({tag, " err"}, {31'h0, err_o}, 32'h0);
    en_i = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; wen_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
    hold_i = 1'b0; flush_i = 1'b0;
    repeat (2) tick();
    checkOutput("reset rdata", rdata_o, 32'h0);
    checkOutput("reset stall", {31'h0, stall_o}, 32'h0);
    checkOutput("reset err", {31'h0, err_o}, 32'h0);
    rst = 1'b0;
    tick();

    // Full-word write then read back.
    writeWord("w1", 32'h10, 32'hDEADBEEF, 4'hF);
    checkOutput("rdata held across write", rdata_o, 32'h0);
    readWord("r1", 32'h10, 32'hDEADBEEF);

    // Single byte lane 2.
    writeWord("lane", 32'h10, 32'h00AA0000, 4'b0100);
    readWord("lane rd", 32'h10, 32'hDEAABEEF);

    // Hold in DONE with the request still presented.
    hold_i = 1'b1;
    applyStimulus(4'h0, 32'h10, 32'h0, n);
    checkOutput("hold stall cycles", 32'(n), 32'd3);
    for (int i = 0; i < 4; i++) begin
      checkOutput("hold stall", {31'h0, stall_o}, 32'h0);
      checkOutput("hold rdata", rdata_o, 32'hDEAABEEF);
      tick();
    end
    hold_i = 1'b0;
    #1;
    checkOutput("no accept in DONE", {31'h0, stall_o}, 32'h0);
    tick();
    checkOutput("accept after DONE", {31'h0, stall_o}, 32'h1);
    applyStimulus(4'h0, 32'h10, 32'h0, n);
    checkOutput("reaccept stall cycles", 32'(n), 32'd3);
    en_i = 1'b0;
    tick();

    // Flush aborts a read.
    writeWord("w40", 32'h40, 32'h55667788, 4'hF);
    en_i = 1'b1; wen_i = 4'h0; addr_i = 32'h40;
    #1;
    checkOutput("flush rd accept stall", {31'h0, stall_o}, 32'h1);
    tick();
    flush_i = 1'b1; en_i = 1'b0;
    #1;
    checkOutput("flush rd busy stall", {31'h0, stall_o}, 32'h1);
    tick();
    flush_i = 1'b0;
    #1;
    checkOutput("flush rd idle stall", {31'h0, stall_o}, 32'h0);
    tick();
    checkOutput("flush rd rdata kept", rdata_o, 32'hDEAABEEF);

    // Flush does not cancel a write.
    en_i = 1'b1; wen_i = 4'hF; addr_i = 32'h20; wdata_i = 32'hCAFEF00D;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    applyStimulus(4'hF, 32'h20, 32'hCAFEF00D, n);
    checkOutput("flush wr remaining stall", 32'(n), 32'd1);
    en_i = 1'b0;
    tick();
    readWord("flush wr rd", 32'h20, 32'hCAFEF00D);

    // Flush in DONE overrides hold.
    hold_i = 1'b1;
    applyStimulus(4'h0, 32'h40, 32'h0, n);
    checkOutput("done flush stall cycles", 32'(n), 32'd3);
    checkOutput("done flush rdata", rdata_o, 32'h55667788);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; hold_i = 1'b0;
    #1;
    checkOutput("done flush to idle", {31'h0, stall_o}, 32'h1);
    applyStimulus(4'h0, 32'h40, 32'h0, n);
    checkOutput("done flush reaccess", 32'(n), 32'd3);
    en_i = 1'b0;
    tick();

    // Reset during the first BUSY cycle of a write drops it.
    writeWord("w30", 32'h30, 32'h0BADF00D, 4'hF);
    en_i = 1'b1; wen_i = 4'hF; addr_i = 32'h30; wdata_i = 32'h12345678;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; en_i = 1'b0;
    #1;
    checkOutput("rst mid stall", {31'h0, stall_o}, 32'h0);
    checkOutput("rst mid rdata", rdata_o, 32'h0);
    tick();
    readWord("rst mid rd", 32'h30, 32'h0BADF00D);

`ifdef DMEM_RANGE_CHECK_EN
    writeWord("w0", 32'h0, 32'h01020304, 4'hF);
    applyStimulus(4'h0, 32'h00001000, 32'h0, n);
    checkOutput("oob rd stall cycles", 32'(n), 32'd3);
    checkOutput("oob rd rdata", rdata_o, 32'h0);
    checkOutput("oob rd err", {31'h0, err_o}, 32'h1);
    en_i = 1'b0;
    tick();
    checkOutput("oob err pulse end", {31'h0, err_o}, 32'h0);
    writeWord("oob wr", 32'h00001000, 32'hFFFFFFFF, 4'hF);
    readWord("oob wr word0", 32'h0, 32'h01020304);
`else
    writeWord("alias wr", 32'h00001050, 32'hA5A5A5A5, 4'hF);
    readWord("alias rd", 32'h50, 32'hA5A5A5A5);
    writeWord("alias wr2", 32'h50, 32'h0F0F0F0F, 4'hF);
    readWord("alias rd2", 32'hFFFFF050, 32'h0F0F0F0F);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
